// File: rtl/bram_pkg.sv
// ============================================================================
// Module   : bram_pkg
// Brief    : Shared widths, ownership-state encoding and read-tag type for the
//            bram port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bram_pkg;

    localparam int BRAM_DATA_W = 16;
    localparam int BRAM_ADDR_W = 10;

    typedef logic [1:0] own_state_t;

    localparam own_state_t ARB  = 2'd0;
    localparam own_state_t OWN0 = 2'd1;
    localparam own_state_t OWN1 = 2'd2;

    // One stage of the read-return tag pipeline
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin picker; on conflict the
//            requester that did not win most recently is chosen.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win_valid,
    output logic       win_id
);

    always_comb begin
        win_valid = |req;
        case (req)
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last;
            default: win_id = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Shares one bram port between two requesters with round-robin
//            arbitration, optional lock ownership and tagged read return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_port_arbiter
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    own_state_t        r_state;
    own_state_t        w_state_nxt;
    logic              r_last;
    logic [1:0]        w_req_elig;
    logic              w_win_valid;
    logic              w_win_id;
    logic              w_win_we;
    logic              w_win_lock;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    logic              r_gnt0;
    logic              r_gnt1;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_we;
    rd_tag_t           r_tag1;
    rd_tag_t           r_tag2;

    rr_pick2 u_pick (
        .req       (w_req_elig),
        .last      (r_last),
        .win_valid (w_win_valid),
        .win_id    (w_win_id)
    );

    assign w_win_we    = w_win_id ? we1    : we0;
    assign w_win_lock  = w_win_id ? lock1  : lock0;
    assign w_win_addr  = w_win_id ? addr1  : addr0;
    assign w_win_wdata = w_win_id ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_win_valid) begin
            if (w_win_lock) begin
                w_state_nxt = w_win_id ? OWN1 : OWN0;
            end else begin
                w_state_nxt = ARB;
            end
        end else begin
            // No winner while owned means the owner's req is low: release unless still locking
            case (r_state)
                OWN0:    if (!lock0) w_state_nxt = ARB;
                OWN1:    if (!lock1) w_state_nxt = ARB;
                ARB:     w_state_nxt = ARB;
                default: w_state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ARB:     w_req_elig = {req1, req0};
            OWN0:    w_req_elig = {1'b0, req0};
            OWN1:    w_req_elig = {req1, 1'b0};
            default: w_req_elig = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_tag1     <= '0;
            r_tag2     <= '0;
        end else begin
            r_gnt0       <= w_win_valid & ~w_win_id;
            r_gnt1       <= w_win_valid &  w_win_id;
            r_tag1.valid <= w_win_valid & ~w_win_we;
            r_tag1.id    <= w_win_id;
            r_tag2       <= r_tag1;
            if (w_win_valid) begin
                r_last     <= w_win_id;
                r_mem_addr <= w_win_addr;
                r_mem_din  <= w_win_wdata;
                r_mem_we   <= w_win_we;
            end else begin
                r_mem_we   <= 1'b0;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    // Tag stage 2 lines up with the bram's registered q
    assign rvalid0  = r_tag2.valid & ~r_tag2.id;
    assign rvalid1  = r_tag2.valid &  r_tag2.id;
    assign rdata    = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Scoreboard bench: directed scenarios plus random traffic checked
//            against a transaction-level arbitration and memory model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    // Behavioural bram port (environment) and the reference memory image
    logic [DW-1:0] bram   [0:1023];
    logic [DW-1:0] shadow [0:1023];

    always @(posedge clk) begin
        mem_q <= bram[mem_addr];
        if (mem_we) bram[mem_addr] <= mem_din;
    end

    typedef struct {
        int            cyc;
        bit            id;
        bit            we;
        bit [AW-1:0]   addr;
        bit [DW-1:0]   din;
    } gnt_exp_t;

    typedef struct {
        int            cyc;
        bit            id;
        bit [DW-1:0]   data;
    } rd_exp_t;

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];

    int cyc    = 0;
    bit rst_s  = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops whatever the model predicted for this cycle, otherwise expects quiet outputs
    bit [AW-1:0] exp_addr = '0;
    bit [DW-1:0] exp_din  = '0;
    always @(negedge clk) begin : mon
        bit eg0, eg1, ewe, er0, er1;
        bit [DW-1:0] ed;
        gnt_exp_t g;
        rd_exp_t  r;
        if (mon_en) begin
            eg0 = 0; eg1 = 0; ewe = 0; er0 = 0; er1 = 0; ed = '0;
            if (rst_s) begin
                exp_addr = '0;
                exp_din  = '0;
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                if (g.id) eg1 = 1; else eg0 = 1;
                ewe      = g.we;
                exp_addr = g.addr;
                exp_din  = g.din;
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                if (r.id) er1 = 1; else er0 = 1;
                ed = r.data;
            end
            check("gnt0", 32'(gnt0), 32'(eg0));
            check("gnt1", 32'(gnt1), 32'(eg1));
            check("mem_we", 32'(mem_we), 32'(ewe));
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_din", 32'(mem_din), 32'(exp_din));
            check("rvalid0", 32'(rvalid0), 32'(er0));
            check("rvalid1", 32'(rvalid1), 32'(er1));
            if (er0 || er1) check("rdata", 32'(rdata), 32'(ed));
        end
    end

    // Requester intent and model state
    bit          p_req[2], p_we[2], p_lock[2];
    bit [AW-1:0] p_addr[2];
    bit [DW-1:0] p_wd[2];
    bit          m_gnt[2];
    int          m_owner = -1;
    int          m_last  = 1;
    bit          gen_en  = 1'b0;

    task automatic model(input bit rst);
        int w;
        gnt_exp_t g;
        rd_exp_t  r;
        w = -1;
        m_gnt[0] = 0;
        m_gnt[1] = 0;
        if (rst) begin
            m_owner = -1;
            m_last  = 1;
            while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
            while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
            return;
        end
        if (m_owner < 0) begin
            if (p_req[0] && p_req[1]) w = 1 - m_last;
            else if (p_req[0])        w = 0;
            else if (p_req[1])        w = 1;
        end else if (p_req[m_owner]) begin
            w = m_owner;
        end else if (!p_lock[m_owner]) begin
            m_owner = -1;
        end
        if (w >= 0) begin
            m_last  = w;
            m_owner = p_lock[w] ? w : -1;
            m_gnt[w] = 1;
            g.cyc = cyc + 1; g.id = w[0]; g.we = p_we[w]; g.addr = p_addr[w]; g.din = p_wd[w];
            gq.push_back(g);
            if (p_we[w]) begin
                shadow[p_addr[w]] = p_wd[w];
            end else begin
                r.cyc = cyc + 2; r.id = w[0]; r.data = shadow[p_addr[w]];
                rq.push_back(r);
            end
            p_req[w] = 0;
        end
    endtask

    task automatic gen();
        for (int i = 0; i < 2; i++) begin
            if (p_req[i]) begin
                if ($urandom_range(0, 19) == 0) p_req[i] = 0;
            end else if ($urandom_range(0, 2) != 0) begin
                p_req[i]  = 1;
                p_we[i]   = ($urandom_range(0, 2) == 0);
                p_lock[i] = ($urandom_range(0, 4) == 0);
                p_addr[i] = AW'($urandom_range(0, 15));
                p_wd[i]   = DW'($urandom);
            end else begin
                p_lock[i] = 0;
            end
        end
    endtask

    // Drive one cycle's inputs (called just after a negedge), predict, then advance
    task automatic step(input bit rst);
        if (gen_en) gen();
        reset  = rst;
        req0   = p_req[0];  req1   = p_req[1];
        we0    = p_we[0];   we1    = p_we[1];
        lock0  = p_lock[0]; lock1  = p_lock[1];
        addr0  = p_addr[0]; addr1  = p_addr[1];
        wdata0 = p_wd[0];   wdata1 = p_wd[1];
        model(rst);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit we, input bit lock, input int a, input int d);
        p_req[i]  = 1;
        p_we[i]   = we;
        p_lock[i] = lock;
        p_addr[i] = AW'(a);
        p_wd[i]   = DW'(d);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            p_req[i] = 0; p_lock[i] = 0; p_we[i] = 0;
        end
    endtask

    // Keep stepping until requester i is granted by the model, bounded
    task automatic step_until_gnt(input int i, input string nm);
        bit got;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(0);
            got = m_gnt[i];
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: requester %0d not granted within 8 cycles", nm, i);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]   = DW'(i * 37 + 16'h1234);
            shadow[i] = DW'(i * 37 + 16'h1234);
        end
        idle_all();
        for (int i = 0; i < 2; i++) begin p_addr[i] = '0; p_wd[i] = '0; end
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        mon_en = 1;
        step(1); step(1);

        // Single accesses: write then read back from the other requester
        set_req(0, 1, 0, 0, 16'h000F); step(0);
        set_req(1, 0, 0, 0, 0);        step(0);
        step(0); step(0);
        set_req(0, 1, 0, 1, 16'h0011);   step(0);
        set_req(0, 1, 0, 510, 16'h0070); step(0);
        step(0);

        // Contention straight after reset: req0 must win first
        step(1);
        for (int k = 0; k < 8; k++) begin
            if (!p_req[0]) set_req(0, 0, 0, 1, 16'h0000);
            if (!p_req[1]) set_req(1, 0, 0, 510, 16'h0000);
            step(0);
        end
        idle_all(); step(0); step(0);

        // Locked read-modify-write on addr 2 while req1 keeps asking
        set_req(0, 0, 1, 2, 0);
        set_req(1, 0, 0, 7, 0);
        step_until_gnt(0, "rmw_read");
        p_lock[0] = 1;
        for (int k = 0; k < 2; k++) step(0);
        set_req(0, 1, 0, 2, int'(shadow[2]) + 3);
        if (!p_req[1]) set_req(1, 0, 0, 7, 0);
        step_until_gnt(0, "rmw_write");
        step(0);
        set_req(0, 0, 0, 2, 0);
        step_until_gnt(0, "rmw_readback");
        idle_all(); step(0); step(0); step(0);

        // Abandoned lock: owner drops req and lock, pending req1 must get in
        set_req(0, 0, 1, 3, 0);
        step_until_gnt(0, "abandon_lock");
        p_req[0] = 0; p_lock[0] = 0;
        set_req(1, 0, 0, 4, 0);
        step_until_gnt(1, "abandon_gnt1");
        idle_all(); step(0); step(0); step(0);

        // Reset the cycle after a read grant; in-flight read must vanish
        set_req(0, 0, 0, 5, 0);
        step_until_gnt(0, "rst_read");
        step(1);
        set_req(0, 0, 0, 6, 0);
        set_req(1, 0, 0, 8, 0);
        step(0);
        step_until_gnt(1, "rst_after");
        idle_all(); step(0); step(0);

        // Idle window
        for (int k = 0; k < 10; k++) step(0);

        // Random traffic with occasional reset
        gen_en = 1;
        for (int k = 0; k < 1500; k++) step($urandom_range(0, 199) == 0);
        gen_en = 0;
        idle_all();
        for (int k = 0; k < 5; k++) step(0);

        check("queues_drained", 32'(gq.size() + rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
